// File: rtl/uart_rx_oversampled_if.sv
// uart_rx_oversampled_if: serial line and baud tick in, received word out.
// master = receiver (reads rx/sample_tick, drives word and flags);
// slave = line driver and word consumer.
interface uart_rx_oversampled_if #(
  parameter int DBITS = 8
);
  logic             rx;
  logic             sample_tick;
  logic [DBITS-1:0] data_out;
  logic             data_valid;
  logic             framing_error;
  logic             parity_error;

  modport master (
    input  rx,
    input  sample_tick,
    output data_out,
    output data_valid,
    output framing_error,
    output parity_error
  );

  modport slave (
    output rx,
    output sample_tick,
    input  data_out,
    input  data_valid,
    input  framing_error,
    input  parity_error
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 16x oversampled UART receiver, optional parity.
// Ports: clk_100MHz, reset (async, active-high), bus (master modport):
//   rx, sample_tick in; data_out, data_valid, framing_error,
//   parity_error out. data_valid is a one-clock strobe per frame.
module uart_rx_oversampled #(
  parameter int DBITS   = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic                   clk_100MHz,
  input  logic                   reset,
  uart_rx_oversampled_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam logic [2:0] NLAST = 3'(DBITS - 1);
  localparam logic [5:0] SLAST = 6'(SB_TICK - 1);

  state_t           state_q, state_d;
  logic [1:0]       sync_q;
  logic             rx_s;
  logic             tick;
  logic [5:0]       s_q, s_d;
  logic [2:0]       n_q, n_d;
  logic [DBITS-1:0] b_q, b_d;
  logic             p_q, p_d;
  logic             pb_q, pb_d;
  logic [DBITS-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             fe_q, fe_d;
  logic             pe_q, pe_d;
  logic             pe_calc;

  assign rx_s = sync_q[1];
  assign tick = bus.sample_tick;

  // p accumulates data ones; pb is the received parity bit.
  always_comb begin
    if (PARITY == 1) begin
      pe_calc = ~(p_q ^ pb_q);
    end else if (PARITY == 2) begin
      pe_calc = p_q ^ pb_q;
    end else begin
      pe_calc = 1'b0;
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      pb_q    <= 1'b0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], bus.rx};
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      pb_q    <= pb_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    pb_d    = pb_q;
    dout_d  = dout_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    dv_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A tick in this cycle is deliberately not counted.
        if (!rx_s) begin
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == 6'd7) begin
            if (!rx_s) begin
              s_d     = '0;
              n_d     = '0;
              p_d     = 1'b0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == 6'd15) begin
            b_d = {rx_s, b_q[DBITS-1:1]};
            p_d = p_q ^ rx_s;
            s_d = '0;
            if (n_q == NLAST) begin
              state_d = (PARITY != 0) ? PAR : STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      PAR: begin
        if (tick) begin
          if (s_q == 6'd15) begin
            pb_d    = rx_s;
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      STOP: begin
        // Leaving mid stop bit lets a back-to-back start be seen.
        if (tick) begin
          if (s_q == SLAST) begin
            dout_d  = b_q;
            fe_d    = ~rx_s;
            pe_d    = pe_calc;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out      = dout_q;
  assign bus.data_valid    = dv_q;
  assign bus.framing_error = fe_q;
  assign bus.parity_error  = pe_q;

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

UART receiver that consumes the one-cycle 16x-oversampling `sample_tick` from the baud rate generator (9600 baud at 100 MHz, tick every 651 clocks). It deserialises an asynchronous `rx` line into parallel words, with optional parity checking and framing-error detection. Each received word is presented to the downstream FIFO/command logic as a one-cycle `data_valid` strobe.

## Interface
- `DBITS`, 8: data bits per frame; legal range 5..8.
- `SB_TICK`, 16: ticks spent in the stop bit; legal values 16, 24, 32 (1, 1.5, 2 stop bits).
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `clk_100MHz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `sample_tick`  in  1  one-cycle pulse at 16x the baud rate, from the baud rate generator.
- `data_out`  out  DBITS  last received word, LSB = first bit on the line.
- `data_valid`  out  1  one-cycle strobe; a frame has completed.
- `framing_error`  out  1  the stop bit of the last frame sampled low.
- `parity_error`  out  1  the parity of the last frame mismatched. Always 0 when PARITY = 0.

## Operation
- `rx` passes through a 2-flop synchronizer. The synchronizer flops reset to 1. All logic uses the synchronized signal `rx_s`.
- Internal state:
  - 6-bit tick counter `s`.
  - 3-bit bit counter `n`.
  - DBITS shift register `b`.
  - parity accumulator `p`.
- IDLE:
  - Waits for `rx_s == 0`, independent of `sample_tick`.
  - On detection, clears `s` and goes to START.
- START: acts only on `sample_tick`.
  - While `s < 7`: increment `s`.
  - At `s == 7` (mid start bit):
    - If `rx_s == 0`: clear `s`, `n` and `p`, then go to DATA.
    - Otherwise: go to IDLE. The glitch is rejected and no outputs change.
- DATA: acts only on `sample_tick`.
  - At `s == 15`:
    - Shift `b <= {rx_s, b[DBITS-1:1]}`, `p <= p ^ rx_s`, and clear `s`.
    - If `n == DBITS-1`: go to PARITY (when PARITY != 0) or STOP.
    - Otherwise: increment `n`.
  - Otherwise: increment `s`.
- PARITY (PARITY != 0 only): acts only on `sample_tick`.
  - At `s == 15`: latch parity bit `pb = rx_s`, clear `s`, go to STOP.
- STOP: acts only on `sample_tick`.
  - At `s == SB_TICK-1`, in one clock edge:
    - `data_out <= b`.
    - `framing_error <= ~rx_s`.
    - `parity_error <=`:
      - odd mode: `~(p ^ pb)`.
      - even mode: `p ^ pb`.
      - PARITY = 0: 0.
    - `data_valid <= 1`.
    - Go to IDLE.
- When DBITS < 8, the word is right-aligned: shift register width is DBITS.
- Completed frames:
  - `data_valid` fires for every completed frame, including frames with errors.
  - The error flags qualify that strobe and hold until the next strobe.
- There is no backpressure. The consumer must accept the strobe.

## Timing
- Reset values:
  - State IDLE; `s`, `n`, `b`, `p` = 0.
  - `data_out` = 0, `data_valid` = 0, `framing_error` = 0, `parity_error` = 0.
- Reset mid-frame:
  - Aborts the frame immediately, with no `data_valid`.
  - After release, the receiver waits in IDLE for a fresh falling edge.
  - A line still low at release is treated as a start bit; glitch rejection in START discards it if it is too short.
- Input latency: 2 clocks from an `rx` edge to `rx_s`.
- Sampling points, in ticks after start detection (±1 tick jitter):
  - Start bit: 8.
  - Data bit k: 8+16(k+1).
  - Parity bit: one bit time after the last data bit.
- `data_valid`:
  - Registered; high for exactly one clock, the clock after the `sample_tick` at which STOP reaches `s == SB_TICK-1`.
  - `data_out` and the flags update on that same edge.
- A `sample_tick` arriving in the same cycle as the IDLE→START transition is not counted.
- Back-to-back frames:
  - STOP returns to IDLE mid stop bit, so a start bit immediately following the stop bit is detected.
  - Zero idle time between frames is supported.
- `sample_tick` may be any period ≥ 2 clocks. Benches may drive it fast (e.g. every 4 clocks) to shorten simulation.

## Test plan
- 8N1, send 0xA5 (line bits 1,0,1,0,0,1,0,1 LSB first) with stop = 1 → single `data_valid` pulse, `data_out` = 0xA5, `framing_error` = 0, `parity_error` = 0.
- 8N1, send 0x3C with stop bit held low → `data_valid` pulses, `data_out` = 0x3C, `framing_error` = 1. Next good frame 0x00 → `framing_error` returns to 0.
- Glitch rejection: `rx` low for 4 ticks, then high → no `data_valid`, FSM in IDLE. A following frame 0x55 is received correctly.
- PARITY = 2 (even), send 0x07 with parity bit 1 → `parity_error` = 0. Same data with parity bit 0 → `parity_error` = 1, `data_valid` still pulses.
- Reset asserted during data bit 4 of a frame → all outputs 0 immediately, no `data_valid`. After release, frame 0x81 → `data_out` = 0x81.
- Three back-to-back frames 0x01, 0xFF, 0x80 with no idle gap, `sample_tick` every 4 clocks → exactly three `data_valid` pulses, in order, no errors.
